// File: rtl/simon_pkg.sv
// -----------------------------------------------------------------------------
// simon_pkg
// Shared constants for the SIMON 96/96 key schedule: word size, number of key
// words, number of round keys, the z2 constant sequence and the controller
// state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package simon_pkg;

  localparam int SIMON_N = 48;
  localparam int SIMON_M = 2;
  localparam int SIMON_T = 52;

  // Element 0 of z2 is the leftmost character, so element j lives at bit 61-j.
  localparam logic [61:0] Z2 =
    62'b10101111011100000011010010011000101000010001111110010110110011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } simon_state_t;

endpackage : simon_pkg

// File: rtl/simon_key_update.sv
// -----------------------------------------------------------------------------
// simon_key_update
// Combinational next-key-word generator for a two-word SIMON key schedule:
//   tmp  = ROR(w1,3); tmp ^= ROR(tmp,1); knew = ~w0 ^ tmp ^ zbit ^ 3
// Ports:
//   w0   in  N  oldest key word k[i]
//   w1   in  N  newest key word k[i+1]
//   zbit in  1  z2 sequence bit for this step
//   knew out N  key word k[i+2]
// -----------------------------------------------------------------------------
module simon_key_update #(
  parameter int N = 48
) (
  input  logic [N-1:0] w0,
  input  logic [N-1:0] w1,
  input  logic         zbit,
  output logic [N-1:0] knew
);

  logic [N-1:0] w_ror3;
  logic [N-1:0] w_tmp;
  logic [N-1:0] w_zext;

  assign w_ror3 = {w1[2:0], w1[N-1:3]};
  assign w_tmp  = w_ror3 ^ {w_ror3[0], w_ror3[N-1:1]};
  assign w_zext = {{(N-1){1'b0}}, zbit};
  assign knew   = ~w0 ^ w_tmp ^ w_zext ^ N'(3);

endmodule : simon_key_update

// File: rtl/simon_key_expansion.sv
// -----------------------------------------------------------------------------
// simon_key_expansion
// Streams the T round keys of a two-word SIMON key schedule, one per accepted
// handshake, starting from a latched master key.
// Ports:
//   clk      in   1    system clock, rising edge
//   rst_n    in   1    synchronous active-low reset
//   start    in   1    begin a new expansion (only honoured in IDLE)
//   key_in   in   M*N  master key, [N-1:0]=k0, [2N-1:N]=k1
//   rk       out  N    current round key k[rk_idx]
//   rk_idx   out  6    index of rk
//   rk_valid out  1    rk/rk_idx valid
//   rk_ready in   1    consumer accepts rk this cycle
//   busy     out  1    expansion in progress
//   done     out  1    one-cycle pulse after the last key is accepted
// -----------------------------------------------------------------------------
module simon_key_expansion
  import simon_pkg::*;
#(
  parameter int N = SIMON_N,
  parameter int M = SIMON_M,
  parameter int T = SIMON_T
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [M*N-1:0] key_in,
  output logic [N-1:0]   rk,
  output logic [5:0]     rk_idx,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic           busy,
  output logic           done
);

  simon_state_t r_state;
  simon_state_t w_state_next;

  logic [N-1:0] r_w0;
  logic [N-1:0] r_w1;
  logic [5:0]   r_i;
  logic [5:0]   r_zidx;
  logic         r_done;

  logic         w_load;
  logic         w_xfer;
  logic         w_last;
  logic         w_zbit;
  logic [N-1:0] w_knew;

  assign w_load = (r_state == ST_IDLE) && start;
  assign w_xfer = (r_state == ST_RUN) && rk_ready;
  assign w_last = (r_i == 6'(T - 1));
  assign w_zbit = Z2[6'd61 - r_zidx];

  simon_key_update #(
    .N (N)
  ) u_key_update (
    .w0   (r_w0),
    .w1   (r_w1),
    .zbit (w_zbit),
    .knew (w_knew)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)           w_state_next = ST_RUN;
      ST_RUN:  if (w_xfer && w_last) w_state_next = ST_IDLE;
      default:                       w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_w0    <= '0;
      r_w1    <= '0;
      r_i     <= '0;
      r_zidx  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_xfer && w_last;
      if (w_load) begin
        r_w0   <= key_in[N-1:0];
        r_w1   <= key_in[2*N-1:N];
        r_i    <= '0;
        r_zidx <= '0;
      end else if (w_xfer && !w_last) begin
        // The final key is already in r_w0, so the words freeze on the last
        // transfer and rk keeps showing k[T-1] while idle.
        r_w0   <= r_w1;
        r_w1   <= w_knew;
        r_i    <= r_i + 6'd1;
        r_zidx <= (r_zidx == 6'd61) ? 6'd0 : r_zidx + 6'd1;
      end
    end
  end

  assign rk       = r_w0;
  assign rk_idx   = r_i;
  assign rk_valid = (r_state == ST_RUN);
  assign busy     = (r_state == ST_RUN);
  assign done     = r_done;

endmodule : simon_key_expansion

// File: tb/tb_simon_key_expansion.sv
// -----------------------------------------------------------------------------
// tb_simon_key_expansion
// Directed bench for simon_key_expansion: reference SIMON 96/96 key stream
// and encryption, stalls, ignored restarts, reset abort and start-in-done.
// -----------------------------------------------------------------------------
module tb_simon_key_expansion;

  localparam logic [95:0] KEY  = 96'h0d0c0b0a0908_050403020100;
  localparam logic [95:0] KEY2 = 96'h1f2e3d4c5b6a_798897a6b5c4;
  localparam logic [95:0] PT   = 96'h2072616c6c69_702065687420;
  localparam logic [95:0] CT   = 96'h602807a462b4_69063d8ff082;
  localparam logic [61:0] ZSEQ =
    62'b10101111011100000011010010011000101000010001111110010110110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [95:0] key_in;
  logic [47:0] rk;
  logic [5:0]  rk_idx;
  logic        rk_valid;
  logic        rk_ready;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [47:0] exp_k [0:51];
  logic [47:0] cx, cy;

  always #5 clk = ~clk;

  simon_key_expansion dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .rk       (rk),
    .rk_idx   (rk_idx),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] rol(input logic [47:0] x, input int s);
    return (x << s) | (x >> (48 - s));
  endfunction

  // Independent key-schedule model producing the expected stream.
  task automatic gen_keys(input logic [95:0] key);
    logic [47:0] t;
    exp_k[0] = key[47:0];
    exp_k[1] = key[95:48];
    for (int j = 2; j < 52; j++) begin
      t = (exp_k[j-1] >> 3) | (exp_k[j-1] << 45);
      t = t ^ ((t >> 1) | (t << 47));
      exp_k[j] = ~exp_k[j-2] ^ t ^ 48'(ZSEQ[61-(j-2)]) ^ 48'd3;
    end
  endtask

  task automatic do_start(input logic [95:0] key);
    key_in = key;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Walks the stream from idx 0, checking each key, optionally stalling,
  // pulsing start with another key, or resetting at given indices.
  task automatic run_keys(input int stall_at, input int restart_at,
                          input int reset_at, input bit check_k1);
    logic [47:0] t;
    cx = PT[95:48];
    cy = PT[47:0];
    for (int i = 0; i < 52; i++) begin
      chk($sformatf("valid[%0d]", i), 96'(rk_valid), 96'd1);
      chk($sformatf("busy[%0d]", i), 96'(busy), 96'd1);
      chk($sformatf("idx[%0d]", i), 96'(rk_idx), 96'(i));
      chk($sformatf("rk[%0d]", i), 96'(rk), 96'(exp_k[i]));
      if (check_k1 && i == 1) chk("k1_const", 96'(rk), 96'h0d0c0b0a0908);
      if (i == stall_at) begin
        rk_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk($sformatf("stall_idx[%0d]", s), 96'(rk_idx), 96'(i));
          chk($sformatf("stall_rk[%0d]", s), 96'(rk), 96'(exp_k[i]));
          chk($sformatf("stall_valid[%0d]", s), 96'(rk_valid), 96'd1);
        end
        rk_ready = 1'b1;
      end
      if (i == reset_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_rk", 96'(rk), 96'd0);
        chk("rst_idx", 96'(rk_idx), 96'd0);
        chk("rst_valid", 96'(rk_valid), 96'd0);
        chk("rst_busy", 96'(busy), 96'd0);
        chk("rst_done", 96'(done), 96'd0);
        $display("reset applied at idx=%0d", i);
        return;
      end
      if (i == restart_at) begin
        start  = 1'b1;
        key_in = KEY2;
      end
      $display("key idx=%0d rk=%h", rk_idx, rk);
      t  = cx;
      cx = cy ^ ((rol(cx, 1) & rol(cx, 8)) ^ rol(cx, 2)) ^ rk;
      cy = t;
      tick();
      start = 1'b0;
      if (i < 51) chk($sformatf("nodone[%0d]", i), 96'(done), 96'd0);
    end
    chk("done_pulse", 96'(done), 96'd1);
    chk("done_valid", 96'(rk_valid), 96'd0);
    chk("done_busy", 96'(busy), 96'd0);
    chk("hold_rk", 96'(rk), 96'(exp_k[51]));
    chk("hold_idx", 96'(rk_idx), 96'd51);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b1;
    tick();
    tick();
    chk("reset_rk", 96'(rk), 96'd0);
    chk("reset_idx", 96'(rk_idx), 96'd0);
    chk("reset_valid", 96'(rk_valid), 96'd0);
    chk("reset_busy", 96'(busy), 96'd0);
    chk("reset_done", 96'(done), 96'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_valid", 96'(rk_valid), 96'd0);

    // Plain run with the reference key and encryption check.
    gen_keys(KEY);
    do_start(KEY);
    chk("k0_const", 96'(rk), 96'h050403020100);
    run_keys(-1, -1, -1, 1'b1);
    chk("ciphertext", {cx, cy}, CT);
    tick();
    chk("done_once", 96'(done), 96'd0);

    // Five-cycle stall at idx 10.
    do_start(KEY);
    run_keys(10, -1, -1, 1'b1);
    chk("ct_stall", {cx, cy}, CT);
    tick();
    chk("done_once_stall", 96'(done), 96'd0);

    // Start with another key at idx 20 must be ignored.
    do_start(KEY);
    run_keys(-1, 20, -1, 1'b1);
    chk("ct_restart", {cx, cy}, CT);
    tick();
    chk("done_once_restart", 96'(done), 96'd0);
    chk("no_new_run", 96'(rk_valid), 96'd0);

    // Reset at idx 30 aborts; a fresh start is needed afterwards.
    do_start(KEY);
    run_keys(-1, -1, 30, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("post_rst_done[%0d]", c), 96'(done), 96'd0);
      chk($sformatf("post_rst_valid[%0d]", c), 96'(rk_valid), 96'd0);
    end
    do_start(KEY);
    chk("restart_idx", 96'(rk_idx), 96'd0);
    chk("restart_rk", 96'(rk), 96'h050403020100);
    run_keys(-1, -1, -1, 1'b1);
    chk("ct_after_rst", {cx, cy}, CT);

    // Start during the done cycle launches a new run immediately.
    gen_keys(KEY2);
    do_start(KEY2);
    chk("sid_valid", 96'(rk_valid), 96'd1);
    chk("sid_idx", 96'(rk_idx), 96'd0);
    chk("sid_rk", 96'(rk), 96'(KEY2[47:0]));
    run_keys(-1, -1, -1, 1'b0);
    tick();
    chk("final_done_low", 96'(done), 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_simon_key_expansion

// File: doc/simon_key_expansion.md
SIMON_KEY_EXPANSION -- requirements
Module: simon_key_expansion

Interface
REQ-001 The block SHALL have parameter N, default 48, meaning word size in bits.
REQ-002 The block SHALL have parameter M, default 2, meaning number of key words; only M=2 is supported.
REQ-003 The block SHALL have parameter T, default 52, meaning number of round keys produced.
REQ-004 The block SHALL have port clk  input  1  meaning single system clock, rising edge.
REQ-005 The block SHALL have port rst_n  input  1  meaning reset, synchronous, active-low.
REQ-006 The block SHALL have port start  input  1  meaning request a new expansion; sampled only in IDLE.
REQ-007 The block SHALL have port key_in  input  M*N  meaning master key, where [N-1:0]=k0 and [2N-1:N]=k1.
REQ-008 The block SHALL have port rk  output  N  meaning current round key k[i].
REQ-009 The block SHALL have port rk_idx  output  6  meaning index i of rk, from 0 to T-1.
REQ-010 The block SHALL have port rk_valid  output  1  meaning rk and rk_idx are valid.
REQ-011 The block SHALL have port rk_ready  input  1  meaning the consumer (round-function stage) accepts rk this cycle.
REQ-012 The block SHALL have port busy  output  1  meaning the block is in the RUN state.
REQ-013 The block SHALL have port done  output  1  meaning a one-cycle pulse after the last key is accepted.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and RUN.
REQ-015 In IDLE with start=1, the block SHALL latch w0<=k0, w1<=k1 and i<=0, and enter RUN on the next edge.
REQ-016 In RUN, the block SHALL drive rk_valid=1, rk=w0 and rk_idx=i; rk_valid SHALL first rise the cycle after start is sampled (latency 1).
REQ-017 A transfer SHALL occur when rk_valid=1 and rk_ready=1; without a transfer, rk and rk_idx SHALL stay stable and no state SHALL change.
REQ-018 On each transfer with i<T-1, the block SHALL update w0<=w1, w1<=knew and i<=i+1.
REQ-019 The new key word SHALL be computed as: tmp=ROR(w1,3); tmp=tmp^ROR(tmp,1); knew = ~w0 ^ tmp ^ z2[i mod 62] ^ 3. ROR is rotate right within N bits; the constant 3 and the z bit are zero-extended to N bits.
REQ-020 z2 SHALL be the 62-element sequence 10101111011100000011010010011000101000010001111110010110110011, where element 0 is the leftmost character.
REQ-021 On the transfer at i=T-1, the block SHALL return to IDLE and pulse done=1 for exactly the following cycle; rk_valid SHALL be 0 in that cycle.
REQ-022 The start input SHALL be ignored while in RUN, and also in the done cycle unless the FSM is already back in IDLE; start=1 in the cycle done is high SHALL begin a new expansion, with rk_valid rising the next cycle.
REQ-023 Changes on key_in SHALL affect the block only in the cycle start is sampled.
REQ-024 In IDLE, rk_valid SHALL be 0, busy SHALL be 0, and rk and rk_idx SHALL hold their last values.
REQ-025 The z index SHALL be computed as a mod-62 counter, and SHALL NOT wrap for T=52.

Reset
REQ-026 When rst_n=0 at a clock edge, the block SHALL enter IDLE and clear rk_valid, busy, done, rk, rk_idx, w0, w1 and i to 0.
REQ-027 Reset asserted during RUN SHALL abort the expansion immediately, with no done pulse.
REQ-028 After reset is released, the block SHALL require a fresh start before producing any keys.

Structure
REQ-029 A shared package simon_pkg SHALL hold the constants SIMON_N=48, SIMON_M=2, SIMON_T=52 and Z2[61:0], plus the state enumeration.
REQ-030 The key-update datapath (REQ-019) SHALL be a combinational sub-module, simon_key_update, with inputs w0, w1 and zbit, and output knew.
REQ-031 The FSM, the word registers and the counter SHALL reside in simon_key_expansion.

Verification
REQ-032 The bench SHALL apply key_in=0x0d0c0b0a0908_050403020100, start, and hold rk_ready=1; it SHALL then check that rk_idx0 carries rk=0x050403020100, rk_idx1 carries rk=0x0d0c0b0a0908, 52 keys are emitted on consecutive cycles, and done pulses once.
REQ-033 The bench SHALL run the same key through the 52 keys chained into roundfunction, with plaintext 0x2072616c6c69_702065687420, and check that the result is ciphertext 0x602807a462b4_69063d8ff082.
REQ-034 The bench SHALL hold rk_ready=0 for 5 cycles at rk_idx=10, then check that rk and rk_idx stay stable, and that the key stream matches a run without stalls.
REQ-035 The bench SHALL pulse start again at rk_idx=20 with a different key_in, then check that the stream continues unchanged and done occurs after idx 51.
REQ-036 The bench SHALL assert rst_n=0 at rk_idx=30, then check that all outputs are 0 the next cycle, no done pulse occurs, and a new start restarts at rk_idx=0 with rk=k0.
REQ-037 The bench SHALL assert start in the done cycle, then check that rk_valid rises the next cycle with rk_idx=0.
